fetch_queue: RTL
================

# fetch_queue

Decoupling buffer between the fetch stage and `new_decode`. It holds fetched instructions together with their PCs and predicted branch targets in three lock-stepped FIFOs. It presents the oldest entry combinationally on `ft_iq_rdata`, `ft_pcq_rdata` and `ft_bpq_rdata`, and it dequeues when the decode/dispatch side accepts that entry. A flush from branch recovery empties it.

## Interface

**Parameters**
- `DEPTH`, default 16: number of entries; must be a power of two, 2 or greater.
- `AF_SLACK`, default 2: `almost_full` asserts when free entries are at or below this value. This covers I-cache responses already in flight.

**Ports**
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: branch-recovery flush; empties the queue at the next edge.
- `enq`  in  1: fetch presents a valid entry.
- `enq_inst`  in  32: instruction word.
- `enq_pc`  in  32: instruction PC.
- `enq_bp_target`  in  32: predicted next PC.
- `full`  out  1: occupancy equals `DEPTH`.
- `almost_full`  out  1: `DEPTH - count <= AF_SLACK`.
- `deq`  in  1: consumer accepts the head entry.
- `empty`  out  1: occupancy equals 0.
- `ft_iq_rdata`  out  32: head instruction; `32'h0` when empty.
- `ft_pcq_rdata`  out  32: head PC; `32'h0` when empty.
- `ft_bpq_rdata`  out  32: head predicted target; `32'h0` when empty.
- `count`  out  $clog2(DEPTH)+1: current occupancy.

## Operation

**Storage**
- Three DEPTH×32 arrays share one head pointer and one tail pointer.
- Each pointer is $clog2(DEPTH)+1 bits wide. The MSB is a wrap bit.
- Empty: pointers are equal.
- Full: pointer index bits are equal and the wrap bits differ.
- `count` is `tail - head` in pointer width (modular). It is not a separate counter.

**Enqueue**
- `enq_fire = enq & ~full & ~flush`.
- On fire, all three fields are written at `tail[idx]` and tail increments. Wrap from index DEPTH-1 to 0 toggles the wrap bit.
- `enq` while full is dropped silently. Fetch must not do this; the bench flags it as a protocol error.

**Dequeue**
- `deq_fire = deq & ~empty & ~flush`. On fire, head increments.
- `deq` while empty is ignored.

**Simultaneous enqueue and dequeue**
- When non-empty and non-full, both fire and `count` is unchanged.
- When full, only the dequeue fires. `full` is evaluated on registered state, so there is no same-cycle pass-through.
- When empty, only the enqueue fires. There is no bypass: the new entry becomes visible the next cycle.

**Flush**
- At the next edge, head and tail are both set to 0.
- Any `enq` or `deq` in the same cycle is discarded.
- Array contents are not cleared.

**Outputs**
- Read data is combinational from `head[idx]`, gated to 0 when `empty`.
- `full`, `empty`, `almost_full` and `count` are pure functions of the registered pointers. None depend combinationally on any input.

**Reset**
- `rst_n` low asynchronously clears head and tail to 0.
- Reset values: `empty=1`, `full=0`, `almost_full=0` (`AF_SLACK < DEPTH`), `count=0`, all rdata `32'h0`.
- Array contents are undefined after reset and never observable, because of the empty gating.
- Reset deassertion mid-stream leaves the queue empty; no stale entry can appear.

## Timing

**Latency**
- An entry enqueued at edge N is on the rdata outputs at N+1 (after clk-to-q), provided it is the head.
- Dequeue at edge N exposes the next entry at N+1.

**Throughput**
- One enqueue and one dequeue per cycle, sustained.

**Flush**
- The flush registered at edge N gives `empty=1` from N+1.
- Fetch may enqueue new-path entries starting in cycle N+1.

**Combinational paths**
- No combinational path from `enq`, `deq` or `flush` to any output.
- The rdata path is array read → mux → decode, and it is the critical path into decode.

## Test plan

1. **Reset and fill:**
   - Stimulus: reset, then enqueue 16 entries with PC=0x1000+4i, inst=0x13+i, bp=PC+4, and no `deq`.
   - Required: `empty` drops the cycle after the first enqueue; `almost_full` rises when `count`=14; `full`=1 when `count`=16; a 17th `enq` leaves state unchanged.
2. **Drain order and wrap:**
   - Stimulus: starting from full, dequeue 10, enqueue 10 more (PC 0x2000…), then drain all.
   - Required: the PC sequence reads 0x1028…0x103C, then 0x2000…0x2024; the wrap bit toggles; `empty`=1 at the end with rdata 0.
3. **Streaming:**
   - Stimulus: `enq` and `deq` both held high for 100 cycles from an empty queue.
   - Required: `count` stays at 1 after the first cycle; the output PC advances every cycle with no bubbles.
4. **Empty/full corner cases:**
   - Stimulus: `enq`+`deq` when empty, then when full.
   - Required: when empty, `count` 0→1; when full, `count` 16→15 and the head advances.
5. **Flush collision:**
   - Stimulus: with `count`=7, assert `flush`, `enq` and `deq` together.
   - Required: next cycle `count`=0, `empty`=1, rdata 0; an enqueue of PC 0x4000 the following cycle appears at the head.
6. **Async reset mid-stream:**
   - Stimulus: pull `rst_n` low between clock edges with `count`=5.
   - Required: `empty`=1 and `count`=0 immediately (no clock needed); operation resumes normally after release.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: three lock-stepped FIFOs (inst, pc, predicted target)
// sharing one head and one tail pointer, with a combinational head read and a flush clear.
module fetch_queue #(
  parameter int DEPTH    = 16,
  parameter int AF_SLACK = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   enq,
  input  logic [31:0]            enq_inst,
  input  logic [31:0]            enq_pc,
  input  logic [31:0]            enq_bp_target,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   deq,
  output logic                   empty,
  output logic [31:0]            ft_iq_rdata,
  output logic [31:0]            ft_pcq_rdata,
  output logic [31:0]            ft_bpq_rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] SLACK_P = PW'(AF_SLACK);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   iq_mem  [DEPTH];
  logic [31:0]   pcq_mem [DEPTH];
  logic [31:0]   bpq_mem [DEPTH];
  logic          enq_fire;
  logic          deq_fire;

  assign enq_fire = enq & ~full  & ~flush;
  assign deq_fire = deq & ~empty & ~flush;

  // DEPTH is a power of two, so a plain increment wraps the index and toggles the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq_fire) tail <= tail + PW'(1);
      if (deq_fire) head <= head + PW'(1);
    end
  end

  // Storage is not reset; empty gating keeps stale contents invisible
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      iq_mem[tail[IW-1:0]]  <= enq_inst;
      pcq_mem[tail[IW-1:0]] <= enq_pc;
      bpq_mem[tail[IW-1:0]] <= enq_bp_target;
    end
  end

  assign count       = tail - head;
  assign empty       = (head == tail);
  assign full        = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
  assign almost_full = (DEPTH_P - count) <= SLACK_P;

  assign ft_iq_rdata  = empty ? 32'h0 : iq_mem[head[IW-1:0]];
  assign ft_pcq_rdata = empty ? 32'h0 : pcq_mem[head[IW-1:0]];
  assign ft_bpq_rdata = empty ? 32'h0 : bpq_mem[head[IW-1:0]];

endmodule
